uart_cfg_frame_rx: RTL

Parametrised serial configuration-frame receiver for the UART. Samples a dedicated control line at 16x oversampling and assembles framed configuration packets. Each packet is validated for header, checksum and trailer. On a valid packet it updates registered baud divisor, data width, stop length and parity settings for the UART TX/RX cores. It adds variable payload length, configurable sync/trailer bytes, framing-error detection and an optional inter-byte timeout.

---
 rtl/uart_cfg_pkg.sv | 59 +++++
 rtl/uart_cfg_frame_rx_if.sv | 29 ++
 rtl/uart_cfg_byte_rx.sv | 104 ++++++++++
 rtl/uart_cfg_frame_rx.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/uart_cfg_pkg.sv
// rtl/uart_cfg_pkg.sv - shared types, reset constants and decode helpers for the config-frame receiver
// Contents:
//   byte_state_t   : byte receiver FSM encoding
//   parser_state_t : frame parser FSM encoding
//   BPS_DIV_RST, DATA_SIZE_RST, STOP_SIZE_RST : output reset values
//   baud_div()     : 16-entry baud divisor table
//   stop_ticks()   : stop-length code to 16x ticks
package uart_cfg_pkg;

  typedef enum logic [1:0] {
    B_IDLE  = 2'd0,
    B_START = 2'd1,
    B_DATA  = 2'd2,
    B_STOP  = 2'd3
  } byte_state_t;

  typedef enum logic [2:0] {
    P_HDR0 = 3'd0,
    P_HDR1 = 3'd1,
    P_PAY  = 3'd2,
    P_CHK  = 3'd3,
    P_TAIL = 3'd4
  } parser_state_t;

  localparam logic [15:0] BPS_DIV_RST   = 16'd325;
  localparam logic [3:0]  DATA_SIZE_RST = 4'd8;
  localparam logic [5:0]  STOP_SIZE_RST = 6'd16;

  function automatic logic [15:0] baud_div(input logic [3:0] sel);
    case (sel)
      4'd0:    baud_div = 16'd28409;
      4'd1:    baud_div = 16'd10416;
      4'd2:    baud_div = 16'd5208;
      4'd3:    baud_div = 16'd2604;
      4'd4:    baud_div = 16'd1302;
      4'd5:    baud_div = 16'd651;
      4'd6:    baud_div = 16'd325;
      4'd7:    baud_div = 16'd217;
      4'd8:    baud_div = 16'd162;
      4'd9:    baud_div = 16'd81;
      4'd10:   baud_div = 16'd72;
      4'd11:   baud_div = 16'd55;
      4'd12:   baud_div = 16'd54;
      4'd13:   baud_div = 16'd27;
      4'd14:   baud_div = 16'd24;
      default: baud_div = 16'd12;
    endcase
  endfunction

  // Code 3 is reserved and falls back to a single stop bit.
  function automatic logic [5:0] stop_ticks(input logic [1:0] code);
    case (code)
      2'd1:    stop_ticks = 6'd24;
      2'd2:    stop_ticks = 6'd32;
      default: stop_ticks = 6'd16;
    endcase
  endfunction

endpackage

// File: rtl/uart_cfg_frame_rx_if.sv
// rtl/uart_cfg_frame_rx_if.sv - decoded configuration bundle driven by the frame receiver
// Signals:
//   cfg_payload  : last accepted payload, byte 0 in the MSBs
//   bps_div, data_size, stop_size, parity_check : decoded UART settings
//   cfg_valid, cfg_chk_err, frame_err, cfg_timeout : 1-cycle event pulses
// Modports: master (receiver drives), slave (UART cores consume)
interface uart_cfg_frame_rx_if #(
  parameter int PAYLOAD_BYTES = 2
);
  logic [8*PAYLOAD_BYTES-1:0] cfg_payload;
  logic [15:0]                bps_div;
  logic [3:0]                 data_size;
  logic [5:0]                 stop_size;
  logic [1:0]                 parity_check;
  logic                       cfg_valid;
  logic                       cfg_chk_err;
  logic                       frame_err;
  logic                       cfg_timeout;

  modport master (
    output cfg_payload, bps_div, data_size, stop_size, parity_check,
    output cfg_valid, cfg_chk_err, frame_err, cfg_timeout
  );

  modport slave (
    input cfg_payload, bps_div, data_size, stop_size, parity_check,
    input cfg_valid, cfg_chk_err, frame_err, cfg_timeout
  );
endinterface

// File: rtl/uart_cfg_byte_rx.sv
// rtl/uart_cfg_byte_rx.sv - synchroniser and 16x-oversampled 8N1 byte receiver
// Ports:
//   clock_bps    in  : 16x baud sample clock
//   reset_n      in  : asynchronous active-low reset
//   control_data in  : asynchronous serial line, idle high
//   rx_byte      out : last assembled byte (valid with byte_valid)
//   byte_valid   out : 1-cycle pulse at a stop-bit centre sampled high
//   frame_err    out : 1-cycle pulse at a stop-bit centre sampled low
module uart_cfg_byte_rx
  import uart_cfg_pkg::*;
(
  input  logic       clock_bps,
  input  logic       reset_n,
  input  logic       control_data,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  logic        sync1, rx_s, rx_d;
  logic        rx_fall;
  byte_state_t state, state_nx;
  logic [3:0]  cnt;
  logic [2:0]  dcnt;
  logic [7:0]  data_q;

  // Flops reset to the idle level so releasing reset never looks like a start edge.
  always_ff @(posedge clock_bps or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      sync1 <= control_data;
      rx_s  <= sync1;
      rx_d  <= rx_s;
    end
  end

  // Arming on a falling edge keeps a line held low after a framing error
  // from being mistaken for a fresh start bit.
  assign rx_fall = rx_d & ~rx_s;

  always_ff @(posedge clock_bps or negedge reset_n) begin
    if (!reset_n) state <= B_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      B_IDLE:  if (rx_fall) state_nx = B_START;
      B_START: begin
        if (rx_s)             state_nx = B_IDLE;
        else if (cnt == 4'd7) state_nx = B_DATA;
      end
      B_DATA:  if (cnt == 4'd15 && dcnt == 3'd7) state_nx = B_STOP;
      B_STOP:  if (cnt == 4'd15) state_nx = B_IDLE;
      default: state_nx = B_IDLE;
    endcase
  end

  always_comb begin
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    if (state == B_STOP && cnt == 4'd15) begin
      byte_valid = rx_s;
      frame_err  = ~rx_s;
    end
  end

  // START counts the 8 low samples up to mid start bit; DATA/STOP then
  // sample every 16th cycle so each bit is taken at its centre.
  always_ff @(posedge clock_bps or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= 4'd0;
      dcnt   <= 3'd0;
      data_q <= 8'd0;
    end else begin
      case (state)
        B_START: begin
          if (rx_s || cnt == 4'd7) cnt <= 4'd0;
          else                     cnt <= cnt + 4'd1;
          dcnt <= 3'd0;
        end
        B_DATA: begin
          cnt <= cnt + 4'd1;
          if (cnt == 4'd15) begin
            data_q[dcnt] <= rx_s;
            dcnt         <= dcnt + 3'd1;
          end
        end
        B_STOP:  cnt <= cnt + 4'd1;
        default: begin
          cnt  <= 4'd0;
          dcnt <= 3'd0;
        end
      endcase
    end
  end

  assign rx_byte = data_q;

endmodule

// File: rtl/uart_cfg_frame_rx.sv
// rtl/uart_cfg_frame_rx.sv - configuration frame parser, checksum, decode and optional timeout
// Optional feature macro: UART_CFG_TIMEOUT_EN (inter-byte timeout counter)
// Ports:
//   clock_bps    in  : 16x baud sample clock
//   reset_n      in  : asynchronous active-low reset
//   control_data in  : serial control line, idle high
//   cfg          master modport of uart_cfg_frame_rx_if : decoded settings and event pulses
module uart_cfg_frame_rx
  import uart_cfg_pkg::*;
#(
  parameter int          PAYLOAD_BYTES = 2,
  parameter logic [7:0]  HDR0          = 8'hAA,
  parameter logic [7:0]  HDR1          = 8'h55,
  parameter logic [7:0]  TAIL          = 8'h55,
  parameter logic [15:0] TIMEOUT_CYC   = 16'd2560
) (
  input  logic                  clock_bps,
  input  logic                  reset_n,
  input  logic                  control_data,
  uart_cfg_frame_rx_if.master   cfg
);

  localparam int IDX_W = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;

  if (PAYLOAD_BYTES < 2) begin : g_bad_payload
    $error("PAYLOAD_BYTES must be at least 2");
  end
  if (TIMEOUT_CYC == 16'd0) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be non-zero");
  end

  logic [7:0]                 rx_byte;
  logic                       bv, fe, to_hit;
  parser_state_t              pstate, pstate_nx;
  logic [IDX_W-1:0]           idx;
  logic [7:0]                 sum_q, chk_q;
  logic [7:0]                 pay_q [PAYLOAD_BYTES];
  logic [8*PAYLOAD_BYTES-1:0] pay_flat;
  logic [15:0]                w;
  logic                       commit, chk_bad;

  uart_cfg_byte_rx u_byte_rx (
    .clock_bps    (clock_bps),
    .reset_n      (reset_n),
    .control_data (control_data),
    .rx_byte      (rx_byte),
    .byte_valid   (bv),
    .frame_err    (fe)
  );

`ifdef UART_CFG_TIMEOUT_EN
  logic [15:0] to_cnt;

  // Byte events take priority so a timeout never coincides with another pulse.
  assign to_hit = (pstate != P_HDR0) && !bv && !fe && (to_cnt == TIMEOUT_CYC);

  always_ff @(posedge clock_bps or negedge reset_n) begin
    if (!reset_n)                             to_cnt <= 16'd0;
    else if (bv || to_hit || pstate == P_HDR0) to_cnt <= 16'd0;
    else                                      to_cnt <= to_cnt + 16'd1;
  end
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge clock_bps or negedge reset_n) begin
    if (!reset_n) pstate <= P_HDR0;
    else          pstate <= pstate_nx;
  end

  always_comb begin
    pstate_nx = pstate;
    if (fe || to_hit) begin
      pstate_nx = P_HDR0;
    end else if (bv) begin
      case (pstate)
        P_HDR0: if (rx_byte == HDR0) pstate_nx = P_HDR1;
        P_HDR1: begin
          if (rx_byte == HDR1)      pstate_nx = P_PAY;
          else if (rx_byte != HDR0) pstate_nx = P_HDR0;
        end
        P_PAY:  if (idx == IDX_W'(PAYLOAD_BYTES - 1)) pstate_nx = P_CHK;
        P_CHK:  pstate_nx = P_TAIL;
        P_TAIL: pstate_nx = (rx_byte == HDR0 && rx_byte != TAIL) ? P_HDR1 : P_HDR0;
        default: pstate_nx = P_HDR0;
      endcase
    end
  end

  always_comb begin
    commit  = 1'b0;
    chk_bad = 1'b0;
    if (bv && pstate == P_TAIL && rx_byte == TAIL) begin
      commit  = (sum_q == chk_q);
      chk_bad = (sum_q != chk_q);
    end
  end

  always_comb begin
    pay_flat = '0;
    for (int i = 0; i < PAYLOAD_BYTES; i++) begin
      pay_flat[8*(PAYLOAD_BYTES-1-i) +: 8] = pay_q[i];
    end
  end

  assign w = {pay_q[0], pay_q[1]};

  always_ff @(posedge clock_bps or negedge reset_n) begin
    if (!reset_n) begin
      idx   <= '0;
      sum_q <= 8'd0;
      chk_q <= 8'd0;
      for (int i = 0; i < PAYLOAD_BYTES; i++) pay_q[i] <= 8'd0;
    end else if (bv) begin
      case (pstate)
        P_HDR1: begin
          idx   <= '0;
          sum_q <= 8'd0;
        end
        P_PAY: begin
          pay_q[idx] <= rx_byte;
          sum_q      <= sum_q + rx_byte;
          idx        <= idx + 1'b1;
        end
        P_CHK:   chk_q <= rx_byte;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock_bps or negedge reset_n) begin
    if (!reset_n) begin
      cfg.cfg_payload  <= '0;
      cfg.bps_div      <= BPS_DIV_RST;
      cfg.data_size    <= DATA_SIZE_RST;
      cfg.stop_size    <= STOP_SIZE_RST;
      cfg.parity_check <= 2'd0;
      cfg.cfg_valid    <= 1'b0;
      cfg.cfg_chk_err  <= 1'b0;
      cfg.frame_err    <= 1'b0;
      cfg.cfg_timeout  <= 1'b0;
    end else begin
      cfg.cfg_valid   <= commit;
      cfg.cfg_chk_err <= chk_bad;
      cfg.frame_err   <= fe;
      cfg.cfg_timeout <= to_hit;
      if (commit) begin
        cfg.cfg_payload  <= pay_flat;
        cfg.bps_div      <= baud_div(w[11:8]);
        cfg.data_size    <= 4'd5 + {2'b00, w[5:4]};
        cfg.stop_size    <= stop_ticks(w[3:2]);
        cfg.parity_check <= w[1:0];
      end
    end
  end

endmodule
